// File: rtl/deser_arb_pkg.sv
// deser_arb_pkg: shared state encoding, default sizes and counter-width helper
package deser_arb_pkg;
    typedef enum logic [1:0] {IDLE_S, COLLECT_S, DONE_S, ABORT_S} state_t;
    localparam int DEF_LANES   = 4;
    localparam int DEF_W       = 16;
    localparam int DEF_TIMEOUT = 64;
    function automatic int tmo_w(input int t);
        return $clog2(t + 1);
    endfunction
endpackage

// File: rtl/deser_lane_arbiter_rr_pick.sv
// rr_pick: first requesting lane at or after ptr, wrapping, as one-hot and index
module rr_pick #(
    parameter  int LANES  = 4,
    localparam int LANE_W = $clog2(LANES)
) (
    input  logic [LANES-1:0]  req,
    input  logic [LANE_W-1:0] ptr,
    output logic [LANES-1:0]  win_oh,
    output logic [LANE_W-1:0] win_idx,
    output logic              hit
);
    logic [LANE_W-1:0] j;
    always_comb begin
        j = '0;
        win_idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            j = LANE_W'((int'(ptr) + i) % LANES);
            if (req[j]) win_idx = j;
        end
    end
    assign hit = |req;
    assign win_oh = hit ? LANES'(1) << win_idx : '0;
endmodule

// File: rtl/deser_lane_arbiter.sv
// deser_lane_arbiter: round-robin shared serial-to-parallel capture with lane tag and stall abort
module deser_lane_arbiter
    import deser_arb_pkg::*;
#(
    parameter  int LANES          = DEF_LANES,
    parameter  int DATA_BUS_WIDTH = DEF_W,
    parameter  int TIMEOUT        = DEF_TIMEOUT,
    localparam int LANE_W         = $clog2(LANES)
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic [LANES-1:0]          req_i,
    input  logic [LANES-1:0]          lane_data_i,
    input  logic [LANES-1:0]          lane_data_val_i,
    output logic [LANES-1:0]          gnt_o,
    output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
    output logic                      deser_data_val_o,
    output logic [LANE_W-1:0]         deser_lane_o,
    output logic                      err_o,
    output logic                      busy_o
);
    localparam int W  = DATA_BUS_WIDTH;
    localparam int CW = $clog2(W);
    localparam int TW = tmo_w(TIMEOUT);
    state_t            state;
    logic [LANE_W-1:0] ptr, g, win_idx, nxt;
    logic [LANES-1:0]  win_oh;
    logic              win_hit, take, last;
    logic [CW-1:0]     bit_cnt;
    logic [TW-1:0]     idle_cnt;
    logic [W-1:0]      sh, word;
    rr_pick #(.LANES(LANES)) u_pick (
        .req(req_i), .ptr(ptr), .win_oh(win_oh), .win_idx(win_idx), .hit(win_hit)
    );
    assign take   = (state == COLLECT_S) && lane_data_val_i[g];
    assign last   = bit_cnt == CW'(W - 1);
    assign word   = {sh[W-2:0], lane_data_i[g]};
    assign nxt    = (g == LANE_W'(LANES - 1)) ? '0 : g + 1'b1;
    assign busy_o = state != IDLE_S;
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state <= IDLE_S;
            gnt_o <= '0;
            deser_data_o <= '0;
            deser_data_val_o <= 1'b0;
            deser_lane_o <= '0;
            err_o <= 1'b0;
            ptr <= '0;
            g <= '0;
            bit_cnt <= '0;
            idle_cnt <= '0;
            sh <= '0;
        end else begin
            deser_data_val_o <= 1'b0;
            err_o <= 1'b0;
            case (state)
                IDLE_S, DONE_S, ABORT_S: begin
                    state <= win_hit ? COLLECT_S : IDLE_S;
                    if (win_hit) begin
                        gnt_o <= win_oh;
                        g <= win_idx;
                        bit_cnt <= '0;
                        idle_cnt <= '0;
                    end
                end
                COLLECT_S: begin
                    if (take) begin
                        sh <= word;
                        idle_cnt <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last) begin
                            gnt_o <= '0;
                            deser_data_o <= word;
                            deser_data_val_o <= 1'b1;
                            deser_lane_o <= g;
                            ptr <= nxt;
                            state <= DONE_S;
                        end
                    end else if (idle_cnt == TW'(TIMEOUT)) begin
                        gnt_o <= '0;
                        err_o <= 1'b1;
                        deser_lane_o <= g;
                        ptr <= nxt;
                        state <= ABORT_S;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= IDLE_S;
            endcase
        end
    end
endmodule

// File: tb/tb_deser_lane_arbiter.sv
// tb_deser_lane_arbiter: directed vector table plus hand-written multi-cycle sequences
module tb_deser_lane_arbiter;
    logic        clk_i = 1'b0;
    logic        srst_i = 1'b1;
    logic [3:0]  req_i = '0;
    logic [3:0]  lane_data_i = '0;
    logic [3:0]  lane_data_val_i = '0;
    logic [3:0]  gnt_o;
    logic [15:0] deser_data_o;
    logic        deser_data_val_o;
    logic [1:0]  deser_lane_o;
    logic        err_o;
    logic        busy_o;
    int          n_chk = 0;
    int          n_fail = 0;

    deser_lane_arbiter dut (
        .clk_i(clk_i), .srst_i(srst_i), .req_i(req_i), .lane_data_i(lane_data_i),
        .lane_data_val_i(lane_data_val_i), .gnt_o(gnt_o), .deser_data_o(deser_data_o),
        .deser_data_val_o(deser_data_val_o), .deser_lane_o(deser_lane_o), .err_o(err_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  req;
        int          lane;
        logic [15:0] word;
        bit          gap;
        logic [3:0]  gnt;
    } vec_t;
    vec_t tbl[5];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        srst_i = 1'b1;
        req_i = '0;
        lane_data_val_i = '0;
        tick();
        tick();
        srst_i = 1'b0;
    endtask

    task automatic noise(input int lane);
        lane_data_i = 4'($urandom);
        lane_data_val_i = 4'($urandom) & ~(4'b1 << lane);
    endtask

    task automatic send(input int lane, input logic [15:0] w, input int lo, input int hi, input bit gap);
        for (int k = lo; k <= hi; k++) begin
            noise(lane);
            lane_data_i[lane] = w[15-k];
            lane_data_val_i[lane] = 1'b1;
            tick();
            if (gap && k != hi) begin
                noise(lane);
                tick();
            end
        end
        lane_data_val_i = '0;
    endtask

    task automatic check_word(input string name, input logic [15:0] w, input int lane);
        check({name, "_val"}, 32'(deser_data_val_o), 1);
        check({name, "_data"}, 32'(deser_data_o), 32'(w));
        check({name, "_lane"}, 32'(deser_lane_o), lane);
        check({name, "_gnt_drop"}, 32'(gnt_o), 0);
        check({name, "_no_err"}, 32'(err_o), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b0100, 2, 16'hA5C3, 1'b0, 4'b0100};
        tbl[1] = '{4'b0010, 1, 16'hFFFF, 1'b1, 4'b0010};
        tbl[2] = '{4'b1010, 1, 16'h1234, 1'b0, 4'b0010};
        tbl[3] = '{4'b1000, 3, 16'h8001, 1'b0, 4'b1000};
        tbl[4] = '{4'b1100, 2, 16'h0F0F, 1'b1, 4'b0100};

        do_reset();
        check("rst_gnt", 32'(gnt_o), 0);
        check("rst_data", 32'(deser_data_o), 0);
        check("rst_val", 32'(deser_data_val_o), 0);
        check("rst_lane", 32'(deser_lane_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_busy", 32'(busy_o), 0);

        foreach (tbl[v]) begin
            do_reset();
            req_i = tbl[v].req;
            tick();
            check($sformatf("vec%0d_gnt", v), 32'(gnt_o), 32'(tbl[v].gnt));
            check($sformatf("vec%0d_busy", v), 32'(busy_o), 1);
            req_i = '0;
            send(tbl[v].lane, tbl[v].word, 0, 15, tbl[v].gap);
            check_word($sformatf("vec%0d", v), tbl[v].word, tbl[v].lane);
            tick();
            check($sformatf("vec%0d_val_pulse", v), 32'(deser_data_val_o), 0);
            check($sformatf("vec%0d_idle", v), 32'(busy_o), 0);
            check($sformatf("vec%0d_hold", v), 32'(deser_data_o), 32'(tbl[v].word));
        end

        // round-robin with all lanes requesting
        do_reset();
        req_i = 4'hF;
        tick();
        check("rr_gnt0", 32'(gnt_o), 32'h1);
        for (int n = 0; n < 4; n++) begin
            send(n, 16'(32'h1111 * (n + 1)), 0, 15, 1'b0);
            check_word($sformatf("rr%0d", n), 16'(32'h1111 * (n + 1)), n);
            tick();
            check($sformatf("rr%0d_next_gnt", n), 32'(gnt_o), 32'(4'b1 << ((n + 1) % 4)));
        end

        // timeout: 5 bits then stall; lane 1 also requesting
        do_reset();
        req_i = 4'b0011;
        tick();
        check("to_gnt", 32'(gnt_o), 32'h1);
        send(0, 16'hF800, 0, 4, 1'b0);
        begin
            int n;
            bit saw_val;
            n = 0;
            saw_val = 1'b0;
            for (int i = 0; i < 200; i++) begin
                noise(0);
                tick();
                n++;
                if (deser_data_val_o) saw_val = 1'b1;
                if (err_o) break;
            end
            check("to_stall_cycles", 32'(n), 65);
            check("to_err", 32'(err_o), 1);
            check("to_lane", 32'(deser_lane_o), 0);
            check("to_gnt_drop", 32'(gnt_o), 0);
            check("to_no_val", 32'(saw_val), 0);
            check("to_data_kept", 32'(deser_data_o), 0);
        end
        tick();
        check("to_err_pulse", 32'(err_o), 0);
        check("to_next_gnt", 32'(gnt_o), 32'h2);

        // bit arriving right after TIMEOUT idle cycles is still accepted
        do_reset();
        req_i = 4'b0001;
        tick();
        req_i = '0;
        send(0, 16'hBEEF, 0, 2, 1'b0);
        begin
            bit saw_err;
            saw_err = 1'b0;
            for (int i = 0; i < 64; i++) begin
                noise(0);
                tick();
                if (err_o) saw_err = 1'b1;
            end
            send(0, 16'hBEEF, 3, 15, 1'b0);
            if (err_o) saw_err = 1'b1;
            check("bnd_no_err", 32'(saw_err), 0);
        end
        check_word("bnd", 16'hBEEF, 0);

        // reset mid-burst restores lane-0-first priority
        do_reset();
        req_i = 4'b0001;
        tick();
        req_i = '0;
        send(0, 16'hC3C3, 0, 15, 1'b0);
        check_word("mr_pre", 16'hC3C3, 0);
        tick();
        req_i = 4'b0100;
        tick();
        check("mr_gnt2", 32'(gnt_o), 32'h4);
        req_i = '0;
        send(2, 16'h9999, 0, 7, 1'b0);
        srst_i = 1'b1;
        tick();
        srst_i = 1'b0;
        check("mr_gnt", 32'(gnt_o), 0);
        check("mr_data", 32'(deser_data_o), 0);
        check("mr_val", 32'(deser_data_val_o), 0);
        check("mr_lane", 32'(deser_lane_o), 0);
        check("mr_err", 32'(err_o), 0);
        check("mr_busy", 32'(busy_o), 0);
        req_i = 4'b0101;
        tick();
        check("mr_new_gnt", 32'(gnt_o), 32'h1);
        req_i = '0;
        send(0, 16'h55AA, 0, 15, 1'b0);
        check_word("mr_post", 16'h55AA, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
